control_sequencer: RTL and testbench
====================================

# control_sequencer

SAP-1 controller/sequencer: the stage directly downstream of the instruction register. It runs a six-state ring counter (T1–T6) and decodes the IR opcode into the 12-bit control word. That word drives the program counter, MAR, RAM, IR, accumulator, ALU, B register and output register. It also provides halt detection, and an optional JMP instruction is available as a compile-time feature.

## Interface
- No parameters; opcode width 4 and control word width 12 are fixed by the SAP-1 architecture.
- clk  input  1  system clock; all state updates on falling edge
- rst  input  1  synchronous, active-low reset, sampled on falling edge of clk
- ir_opcode  input  4  upper nibble of IR (ir_out), valid from T4
- con  output  12  control word {cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n}, bit 11 = cp
- lp_n  output  1  load-PC-from-bus, active-low (JMP only; see Configuration)
- tstate  output  6  one-hot timing state, bit0 = T1 … bit5 = T6; 0 in IDLE/HALT
- hlt  output  1  high while in HALT

## Operation
- States: IDLE, T1..T6, HALT. The state register and opcode latch update on negedge clk. con, lp_n, tstate and hlt are decoded combinationally from the registered state and the latched opcode.
- Transitions:
  - IDLE→T1.
  - T1→T2→T3→T4→T5→T6→T1.
  - T4→HALT if the latched opcode is 1111.
  - HALT→HALT until reset.
- Opcode latch: captures ir_opcode on the T3→T4 edge. The IR loads at the posedge inside T3, so the value is stable by then. The latch holds through T6; ir_opcode changes outside that edge are ignored.
- Fetch control words (all opcodes):
  - T1 = 0x5E3 (ep, lm_n)
  - T2 = 0xBE3 (cp)
  - T3 = 0x263 (ce_n, li_n)
- LDA 0000: T4 0x1A3 (ei_n, lm_n); T5 0x2C3 (ce_n, la_n); T6 0x3E3.
- ADD 0001: T4 0x1A3; T5 0x2E1 (ce_n, lb_n); T6 0x3C7 (la_n, eu).
- SUB 0010: T4 0x1A3; T5 0x2E1; T6 0x3CF (la_n, su, eu).
- OUT 1110: T4 0x3F2 (ea, lo_n); T5, T6 0x3E3.
- HLT 1111: T4 0x3E3; the next negedge enters HALT. In HALT: con = 0x3E3, hlt = 1, tstate = 0.
- Any other opcode is a NOP: T4–T6 output 0x3E3.
- IDLE and HALT both output con = 0x3E3 and lp_n = 1. Outside JMP T4, lp_n = 1 always.

## Timing
- Reset values (rst low at a negedge): state IDLE, con = 0x3E3, lp_n = 1, tstate = 0, hlt = 0, opcode latch = 0000.
- The first negedge with rst high enters T1. Reset-to-first-fetch latency is one clock.
- Reset mid-instruction (any T-state or HALT) returns to IDLE on that edge; reset takes priority over every transition.
- Every instruction takes exactly 6 clocks (T1..T6), except HLT, which stops after T4.
- Control words change only on negedge, so they are stable at each posedge where MAR/IR/registers load.
- Wrap-around: T6→T1 is unconditional; there is no stall or pause input.

## Configuration
- Macro: CTRL_JMP_EN.
- Defined: opcode 0011 = JMP.
  - T4: con = 0x3A3 (ei_n) with lp_n = 0, loading the IR operand into the PC at the next negedge.
  - T5, T6: con = 0x3E3.
- Undefined: opcode 0011 decodes as a NOP. lp_n is tied to 1 (the port is still present).

## Test plan
- Reset then release, ir_opcode=0000 → con sequence 0x3E3 (IDLE), then 0x5E3, 0xBE3, 0x263, 0x1A3, 0x2C3, 0x3E3; tstate 0, then 01, 02, 04, 08, 10, 20.
- ir_opcode=0010 at T3 edge, then changed to 0001 during T4 → T4–T6 = 0x1A3, 0x2E1, 0x3CF; the change is ignored.
- ir_opcode=1110 → T4 = 0x3F2, T5/T6 = 0x3E3; next cycle tstate=01 (wrap to T1).
- ir_opcode=1111 → T4 0x3E3, then hlt=1, tstate=0, con=0x3E3 held for 20+ clocks; rst low for one negedge → IDLE, hlt=0, then T1.
- rst asserted during T5 of ADD → next negedge gives IDLE/0x3E3; the following cycle is T1 = 0x5E3; no T6 0x3C7 is emitted.
- ir_opcode=0011 with CTRL_JMP_EN → T4 con=0x3A3, lp_n=0; without the macro → T4 con=0x3E3, lp_n=1.

Source files
------------

// File: rtl/control_sequencer.sv
// SAP-1 controller/sequencer: T1..T6 ring counter, opcode latch, control word decode.
// Optional JMP (opcode 0011, drives lp_n) is enabled with `define CTRL_JMP_EN.
module control_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  ir_opcode,
  output logic [11:0] con,
  output logic        lp_n,
  output logic [5:0]  tstate,
  output logic        hlt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ST1  = 3'd1,
    ST2  = 3'd2,
    ST3  = 3'd3,
    ST4  = 3'd4,
    ST5  = 3'd5,
    ST6  = 3'd6,
    HALT = 3'd7
  } state_t;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;
`ifdef CTRL_JMP_EN
  localparam logic [3:0] OP_JMP = 4'b0011;
`endif

  localparam logic [11:0] CW_NOP = 12'h3E3;
  localparam logic [11:0] CW_T1  = 12'h5E3;
  localparam logic [11:0] CW_T2  = 12'hBE3;
  localparam logic [11:0] CW_T3  = 12'h263;
  localparam logic [11:0] CW_MAR = 12'h1A3;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] op;

  // Everything moves on the falling edge so loads at posedge see stable words.
  always_ff @(negedge clk) begin
    if (!rst) begin
      state <= IDLE;
      op    <= 4'b0000;
    end else begin
      state <= state_nxt;
      if (state == ST3)
        op <= ir_opcode;
    end
  end

  always_comb begin
    state_nxt = state;
    con       = CW_NOP;
    lp_n      = 1'b1;
    tstate    = 6'b000000;
    hlt       = 1'b0;
    unique case (state)
      IDLE: state_nxt = ST1;
      ST1: begin
        state_nxt = ST2;
        tstate    = 6'b000001;
        con       = CW_T1;
      end
      ST2: begin
        state_nxt = ST3;
        tstate    = 6'b000010;
        con       = CW_T2;
      end
      ST3: begin
        state_nxt = ST4;
        tstate    = 6'b000100;
        con       = CW_T3;
      end
      ST4: begin
        state_nxt = (op == OP_HLT) ? HALT : ST5;
        tstate    = 6'b001000;
        case (op)
          OP_LDA,
          OP_ADD,
          OP_SUB: con = CW_MAR;
          OP_OUT: con = 12'h3F2;
`ifdef CTRL_JMP_EN
          OP_JMP: begin
            con  = 12'h3A3;
            lp_n = 1'b0;
          end
`endif
          default: con = CW_NOP;
        endcase
      end
      ST5: begin
        state_nxt = ST6;
        tstate    = 6'b010000;
        case (op)
          OP_LDA:  con = 12'h2C3;
          OP_ADD,
          OP_SUB:  con = 12'h2E1;
          default: con = CW_NOP;
        endcase
      end
      ST6: begin
        state_nxt = ST1;
        tstate    = 6'b100000;
        case (op)
          OP_ADD:  con = 12'h3C7;
          OP_SUB:  con = 12'h3CF;
          default: con = CW_NOP;
        endcase
      end
      HALT: begin
        state_nxt = HALT;
        hlt       = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer with an expected-value queue.
module tb_control_sequencer;

  logic        clk;
  logic        rst;
  logic [3:0]  ir_opcode;
  logic [11:0] con;
  logic        lp_n;
  logic [5:0]  tstate;
  logic        hlt;

  typedef struct packed {
    logic [11:0] con;
    logic [5:0]  ts;
    logic        hlt;
    logic        lp;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  control_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .ir_opcode (ir_opcode),
    .con       (con),
    .lp_n      (lp_n),
    .tstate    (tstate),
    .hlt       (hlt)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] got,
                     input logic [11:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Push expectation, let the DUT take one falling edge, check at the posedge.
  task automatic tick(input logic [11:0] c, input logic [5:0] ts,
                      input logic h, input logic lp);
    exp_t e;
    exp_t x;
    e.con = c;
    e.ts  = ts;
    e.hlt = h;
    e.lp  = lp;
    exp_q.push_back(e);
    @(negedge clk);
    @(posedge clk);
    x = exp_q.pop_front();
    chk("con", con, x.con);
    chk("tstate", {6'd0, tstate}, {6'd0, x.ts});
    chk("hlt", {11'd0, hlt}, {11'd0, x.hlt});
    chk("lp_n", {11'd0, lp_n}, {11'd0, x.lp});
  endtask

  task automatic fetch(input logic [3:0] op);
    tick(12'h5E3, 6'h01, 1'b0, 1'b1);
    tick(12'hBE3, 6'h02, 1'b0, 1'b1);
    tick(12'h263, 6'h04, 1'b0, 1'b1);
    ir_opcode = op;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    ir_opcode = 4'b0000;
    @(posedge clk);
    tick(12'h3E3, 6'h00, 1'b0, 1'b1);
    rst = 1'b1;

    // LDA
    fetch(4'b0000);
    tick(12'h1A3, 6'h08, 1'b0, 1'b1);
    tick(12'h2C3, 6'h10, 1'b0, 1'b1);
    tick(12'h3E3, 6'h20, 1'b0, 1'b1);

    // SUB, opcode changes after latch
    fetch(4'b0010);
    tick(12'h1A3, 6'h08, 1'b0, 1'b1);
    ir_opcode = 4'b0001;
    tick(12'h2E1, 6'h10, 1'b0, 1'b1);
    tick(12'h3CF, 6'h20, 1'b0, 1'b1);

    // OUT, then wrap to T1
    fetch(4'b1110);
    tick(12'h3F2, 6'h08, 1'b0, 1'b1);
    tick(12'h3E3, 6'h10, 1'b0, 1'b1);
    tick(12'h3E3, 6'h20, 1'b0, 1'b1);
    tick(12'h5E3, 6'h01, 1'b0, 1'b1);

    // JMP / NOP 0011
    tick(12'hBE3, 6'h02, 1'b0, 1'b1);
    tick(12'h263, 6'h04, 1'b0, 1'b1);
    ir_opcode = 4'b0011;
`ifdef CTRL_JMP_EN
    tick(12'h3A3, 6'h08, 1'b0, 1'b0);
`else
    tick(12'h3E3, 6'h08, 1'b0, 1'b1);
`endif
    tick(12'h3E3, 6'h10, 1'b0, 1'b1);
    tick(12'h3E3, 6'h20, 1'b0, 1'b1);

    // Unassigned opcode is a NOP
    fetch(4'b0101);
    tick(12'h3E3, 6'h08, 1'b0, 1'b1);
    tick(12'h3E3, 6'h10, 1'b0, 1'b1);
    tick(12'h3E3, 6'h20, 1'b0, 1'b1);

    // ADD interrupted by reset in T5
    fetch(4'b0001);
    tick(12'h1A3, 6'h08, 1'b0, 1'b1);
    tick(12'h2E1, 6'h10, 1'b0, 1'b1);
    rst = 1'b0;
    tick(12'h3E3, 6'h00, 1'b0, 1'b1);
    rst = 1'b1;

    // HLT and hold
    fetch(4'b1111);
    tick(12'h3E3, 6'h08, 1'b0, 1'b1);
    ir_opcode = 4'b0000;
    for (int i = 0; i < 22; i++)
      tick(12'h3E3, 6'h00, 1'b1, 1'b1);
    rst = 1'b0;
    tick(12'h3E3, 6'h00, 1'b0, 1'b1);
    rst = 1'b1;
    tick(12'h5E3, 6'h01, 1'b0, 1'b1);
    tick(12'hBE3, 6'h02, 1'b0, 1'b1);

    chk("queue_empty", 12'(exp_q.size()), 12'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
